// File: rtl/i2s_tx_pkg.sv
// Shared types and constants for the I2S transmit serializer.
package i2s_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DELAY,
        SHIFT,
        PAD
    } tx_state_e;

    localparam logic MODE_I2S  = 1'b0;
    localparam logic MODE_LJ   = 1'b1;
    localparam int   BUF_DEPTH = 2;
    localparam int   BUF_CNT_W = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/i2s_tx_fifo2.sv
// Two-entry input buffer with valid/ready push, explicit pop and flush.
// Entry 0 is always the head, so the head word is a plain register output.
module i2s_tx_fifo2 import i2s_tx_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0]    slot0;
    logic [DATA_W-1:0]    slot1;
    logic [BUF_CNT_W-1:0] count;
    logic                 push_ok;
    logic                 pop_ok;

    assign full_o  = (count == BUF_CNT_W'(BUF_DEPTH));
    assign empty_o = (count == '0);
    assign head_o  = slot0;
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Storage and occupancy; a simultaneous push/pop only occurs with one entry held.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            count <= '0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (empty_o) slot0 <= data_i;
                    else         slot1 <= data_i;
                    count <= count + BUF_CNT_W'(1);
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - BUF_CNT_W'(1);
                end
                2'b11: begin
                    slot0 <= data_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S / left-justified transmit serializer, MSB first, aligned to WS edges.
// Optional feature macro: I2S_TX_UNDERRUN_REPEAT_EN (replay last word on underrun).
//
// state | meaning
// IDLE  | disabled, buffer flushed, sd_o low
// SYNC  | enabled, waiting for first WS edge
// DELAY | one-bit I2S delay before the MSB
// SHIFT | word being shifted out, busy_o high
// PAD   | word finished, sd_o low until next WS edge
module i2s_tx_serializer import i2s_tx_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_en_i,
    input  logic              cfg_mode_i,
    input  logic [4:0]        cfg_word_size_i,
    input  logic              ws_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic              sd_o,
    output logic              busy_o,
    output logic              underrun_o
);

    tx_state_e         state;
    tx_state_e         state_nx;
    logic              ws_d;
    logic              ws_edge;
    logic [DATA_W-1:0] shreg;
    logic [4:0]        cnt;
    logic [4:0]        cnt_m1;
    logic              load;
    logic              sd_nx;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] load_word;

    assign ws_edge      = ws_i ^ ws_d;
    assign cnt_m1       = cnt - 5'd1;
    assign data_ready_o = cfg_en_i & ~fifo_full & ~rst_i;
    assign push         = data_valid_i & data_ready_o;
    assign pop          = load & ~fifo_empty;

    i2s_tx_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (~cfg_en_i),
        .push_i  (push),
        .data_i  (data_i),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    logic [DATA_W-1:0] last_word;

    // Remember the last word taken from the buffer; forgotten when disabled.
    always_ff @(posedge clk_i) begin
        if (rst_i || !cfg_en_i) last_word <= '0;
        else if (pop)           last_word <= fifo_head;
    end

    assign load_word = fifo_empty ? last_word : fifo_head;
`else
    assign load_word = fifo_empty ? '0 : fifo_head;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; a WS edge in SYNC, SHIFT or PAD always opens a new slot.
    always_comb begin
        state_nx = state;
        if (!cfg_en_i) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:  state_nx = SYNC;
                SYNC, PAD: begin
                    if (ws_edge) state_nx = (cfg_mode_i == MODE_I2S) ? DELAY : SHIFT;
                end
                DELAY: state_nx = SHIFT;
                SHIFT: begin
                    if (ws_edge)          state_nx = (cfg_mode_i == MODE_I2S) ? DELAY : SHIFT;
                    else if (cnt == 5'd0) state_nx = PAD;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output/control decode: slot load strobe, next serial bit, status flags.
    always_comb begin
        load  = 1'b0;
        sd_nx = 1'b0;
        if (cfg_en_i && !rst_i) begin
            unique case (state)
                SYNC, PAD: begin
                    if (ws_edge && cfg_mode_i == MODE_LJ) load = 1'b1;
                end
                DELAY: load = 1'b1;
                SHIFT: begin
                    if (ws_edge) begin
                        if (cfg_mode_i == MODE_LJ) load = 1'b1;
                    end else if (cnt != 5'd0) begin
                        sd_nx = shreg[cnt_m1];
                    end
                end
                default: ;
            endcase
        end
        // The MSB goes straight to sd_o at load so it appears one cycle later.
        if (load) sd_nx = load_word[cfg_word_size_i];
    end

    assign busy_o     = (state == SHIFT);
    assign underrun_o = load & fifo_empty;

    // Datapath: WS history, shift register, bit counter and registered serial output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ws_d  <= 1'b0;
            sd_o  <= 1'b0;
            shreg <= '0;
            cnt   <= 5'd0;
        end else begin
            ws_d <= ws_i;
            sd_o <= sd_nx;
            if (load) begin
                shreg <= load_word;
                cnt   <= cfg_word_size_i;
            end else if (state == SHIFT && cnt != 5'd0) begin
                cnt <= cnt_m1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Scoreboard bench for i2s_tx_serializer: each slot's expected word, length and
// underrun count is queued by the stimulus and checked when busy_o falls.
module tb_i2s_tx_serializer;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic [4:0]  size;
    logic        ws;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic        sd;
    logic        busy;
    logic        ur;

    i2s_tx_serializer #(.DATA_W(32)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_en_i        (en),
        .cfg_mode_i      (mode),
        .cfg_word_size_i (size),
        .ws_i            (ws),
        .data_i          (data),
        .data_valid_i    (valid),
        .data_ready_o    (ready),
        .sd_o            (sd),
        .busy_o          (busy),
        .underrun_o      (ur)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          nbits;
        int          urs;
    } slot_t;

    slot_t       exp_q[$];
    slot_t       e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          edge_cyc = 0;
    int          rise_cyc = 0;
    bit          mon_on = 1'b0;
    bit          in_slot = 1'b0;
    logic [31:0] mon_word = '0;
    int          mon_bits = 0;
    int          mon_ur = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: close a slot when busy falls, then count underrun pulses, then collect bits.
    always @(negedge clk) begin
        if (mon_on) begin
            if (busy !== 1'b1) begin
                chk("sd_low_when_not_busy", {31'd0, sd}, 32'd0);
                if (in_slot) begin
                    in_slot = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_slot actual=%0h/%0d bits required=no slot", mon_word, mon_bits);
                    end else begin
                        e = exp_q.pop_front();
                        chk("slot_word", mon_word, e.word);
                        chk("slot_bits", 32'(mon_bits), 32'(e.nbits));
                        chk("slot_underrun", 32'(mon_ur), 32'(e.urs));
                    end
                    mon_ur = 0;
                end
            end
            if (ur === 1'b1) mon_ur++;
            if (busy === 1'b1) begin
                if (!in_slot) begin
                    in_slot  = 1'b1;
                    rise_cyc = cyc;
                    mon_word = '0;
                    mon_bits = 0;
                end
                mon_word = {mon_word[30:0], sd};
                mon_bits++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic toggle_ws();
        ws = ~ws;
        edge_cyc = cyc;
    endtask

    task automatic expect_slot(input logic [31:0] w, input int n, input int u);
        slot_t s;
        s.word  = w;
        s.nbits = n;
        s.urs   = u;
        exp_q.push_back(s);
    endtask

    task automatic push_word(input logic [31:0] w);
        int n;
        n = 0;
        data  = w;
        valid = 1'b1;
        @(negedge clk);
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=ready %b required=1", ready);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; en = 1'b1; mode = 1'b0; size = 5'd15;
        ws = 1'b0; data = '0; valid = 1'b0;

        // Reset state
        ticks(3);
        @(negedge clk);
        chk("rst_sd", {31'd0, sd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_underrun", {31'd0, ur}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        tick();
        rst = 1'b0;
        mon_on = 1'b1;

        // I2S basic, 16-bit words, plus ready recovery after load
        ticks(3);
        push_word(32'hA5F0); expect_slot(32'hA5F0, 16, 0);
        push_word(32'h1234); expect_slot(32'h1234, 16, 0);
        @(negedge clk);
        chk("full_ready", {31'd0, ready}, 32'd0);
        tick();
        toggle_ws();
        @(negedge clk); chk("ready_edge_cycle", {31'd0, ready}, 32'd0);
        @(negedge clk); chk("ready_delay_cycle", {31'd0, ready}, 32'd0);
        @(negedge clk); chk("ready_after_load", {31'd0, ready}, 32'd1);
        ticks(30);
        chk("i2s_latency", 32'(rise_cyc - edge_cyc), 32'd2);
        toggle_ws();
        ticks(32);

        // Underrun after a 0x00FF word
        push_word(32'h00FF); expect_slot(32'h00FF, 16, 0);
        toggle_ws(); ticks(32);
        expect_slot(REPEAT ? 32'h00FF : 32'h0, 16, 1);
        toggle_ws(); ticks(32);

        // Left-justified, 24-bit word
        mode = 1'b1; size = 5'd23;
        push_word(32'hABCDEF); expect_slot(32'hABCDEF, 24, 0);
        toggle_ws(); ticks(32);
        chk("lj_latency", 32'(rise_cyc - edge_cyc), 32'd1);

        // Backpressure: third word held off until a slot load frees an entry
        push_word(32'h123456); expect_slot(32'h123456, 24, 0);
        push_word(32'h654321); expect_slot(32'h654321, 24, 0);
        data = 32'h0F0F0F; valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_ready", {31'd0, ready}, 32'd0);
        end
        tick();
        toggle_ws();
        @(negedge clk); chk("lj_ready_load_cycle", {31'd0, ready}, 32'd0);
        @(negedge clk); chk("lj_ready_after_load", {31'd0, ready}, 32'd1);
        @(posedge clk); #1; valid = 1'b0;
        expect_slot(32'h0F0F0F, 24, 0);
        ticks(30); toggle_ws();
        ticks(32); toggle_ws();
        ticks(32);

        // Truncation: 32-bit words, WS every 8 cycles, I2S
        mode = 1'b0; size = 5'd31;
        push_word(32'hDEADBEEF); expect_slot(32'h6F, 7, 0);
        push_word(32'hCAFEF00D); expect_slot(32'h65, 7, 0);
        expect_slot(REPEAT ? 32'hCAFEF00D : 32'h0, 32, 1);
        toggle_ws(); ticks(8);
        toggle_ws(); ticks(8);
        toggle_ws(); ticks(40);

        // Reset in the middle of SHIFT
        size = 5'd15;
        push_word(32'hFFFF); expect_slot(32'hF, 4, 0);
        push_word(32'h5555);
        toggle_ws(); ticks(5);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_sd", {31'd0, sd}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst_flush", {31'd0, ready}, 32'd1);
        ticks(3);
        expect_slot(32'h0, 16, 1);
        toggle_ws(); ticks(32);

        // Disable mid-slot, re-enable, wait for WS edge
        push_word(32'hFFFF); expect_slot(32'hF, 4, 0);
        push_word(32'hAAAA);
        toggle_ws(); ticks(5);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("dis_sd", {31'd0, sd}, 32'd0);
        chk("dis_busy", {31'd0, busy}, 32'd0);
        chk("dis_ready", {31'd0, ready}, 32'd0);
        tick();
        en = 1'b1;
        ticks(10);
        @(negedge clk);
        chk("no_restart_before_edge", {31'd0, busy}, 32'd0);
        tick();
        expect_slot(32'h0, 16, 1);
        toggle_ws(); ticks(32);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
